// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: serial FSM state encoding and a constant clog2 helper.
// No logic and no latency of its own; the package carries no handshake.
// Imported by the serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Ceiling log2, usable in constant expressions; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out bo.
// Purely combinational, zero cycles of latency.
// No handshake and no backpressure; the outputs follow the inputs.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bin;
    assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b mod 2^WIDTH, bout = unsigned borrow.
// Latency: WIDTH+1 cycles from accepted start to the done pulse; one op per WIDTH+1 cycles.
// start is taken only while busy=0 (IDLE or the DONE cycle) and is ignored during SHIFT.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] d_sr_q;
    logic             br_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             bit_d;
    logic             br_d;
    logic [WIDTH-1:0] d_sr_d;
    logic             last_bit;

    full_subtractor u_fs (
        .x   (a_sr_q[0]),
        .y   (b_sr_q[0]),
        .bin (br_q),
        .d   (bit_d),
        .bo  (br_d)
    );

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        d_sr_d   = {bit_d, d_sr_q[WIDTH-1:1]};
        last_bit = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        d_sr_q  <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    d_sr_q <= d_sr_d;
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // Publish the completed result together with the done pulse.
                        diff_q  <= d_sr_d;
                        bout_q  <= br_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        d_sr_q  <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with hand-computed expected results.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    int n_chk = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge, then scramble the inputs.
    task automatic launch(input logic [7:0] av, input logic [7:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
    endtask

    // Counts edges until done (bounded) and busy-high cycles seen on the way.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb);
        int lat;
        int bc;
        launch(av, bv);
        wait_done(lat, bc);
        check({tag, "_cycles_to_done"}, 32'(lat + 1), 32'd9);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        step();
        check({tag, "_done_pulse_len"}, 32'(done), 32'd0);
        check({tag, "_diff_hold"}, 32'(diff), 32'(ed));
        check({tag, "_bout_hold"}, 32'(bout), 32'(eb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bc;
        int seen;

        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        step();

        run_op("p35m12", 8'h35, 8'h12, 8'h23, 1'b0);
        run_op("p12m35", 8'h12, 8'h35, 8'hDD, 1'b1);
        run_op("p00m01", 8'h00, 8'h01, 8'hFF, 1'b1);
        run_op("pFFmFF", 8'hFF, 8'hFF, 8'h00, 1'b0);
        run_op("p80m7F", 8'h80, 8'h7F, 8'h01, 1'b0);

        // Second start while busy must be ignored.
        launch(8'h35, 8'h12);
        step();
        step();
        a     = 8'h00;
        b     = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 8'hA5;
        b     = 8'h5A;
        wait_done(lat, bc);
        check("midstart_edges", 32'(lat + 3), 32'd8);
        check("midstart_diff", 32'(diff), 32'h23);
        check("midstart_bout", 32'(bout), 32'd0);
        step();
        check("midstart_no_restart_busy", 32'(busy), 32'd0);
        check("midstart_no_restart_done", 32'(done), 32'd0);
        step();

        // Back-to-back: start held through the DONE cycle.
        a     = 8'h35;
        b     = 8'h12;
        start = 1'b1;
        step();
        a     = 8'h12;
        b     = 8'h35;
        wait_done(lat, bc);
        check("b2b_first_edges", 32'(lat), 32'd8);
        check("b2b_first_diff", 32'(diff), 32'h23);
        check("b2b_first_bout", 32'(bout), 32'd0);
        step();
        start = 1'b0;
        check("b2b_no_idle_busy", 32'(busy), 32'd1);
        wait_done(lat, bc);
        check("b2b_gap", 32'(lat + 1), 32'd9);
        check("b2b_second_diff", 32'(diff), 32'hDD);
        check("b2b_second_bout", 32'(bout), 32'd1);
        step();

        // Reset mid-operation.
        launch(8'h35, 8'h12);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) seen++;
            step();
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        run_op("postrst", 8'h12, 8'h35, 8'hDD, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
